// File: rtl/uart_debug_pkg.sv
// ---------------------------------------------------------------------------
// uart_debug_pkg
// Shared definitions for the UART transmit arbiter slice:
//   - default source count and stall-watchdog limit
//   - arbiter FSM state encoding
//   - ASCII framing constants used by debug message producers
//   - packed layout of the arbiter debug/state bus
//   - small wrap-around helper for source indices
// ---------------------------------------------------------------------------
package uart_debug_pkg;

  localparam int DEF_NUM_SRC        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 60000;  // 1 ms at 60 MHz

  // Arbiter FSM state encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // ASCII constants for message framing
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_RBRACK = 8'h5D;

  // Debug bus layout: {state, grant_idx, last_grant}
  typedef struct packed {
    logic       state;
    logic [2:0] grant_idx;
    logic [2:0] last_grant;
  } arb_dbg_t;

  // Next source index after v, wrapping at n
  function automatic logic [2:0] next_idx(input logic [2:0] v, input int n);
    if (int'(v) >= n - 1) return 3'd0;
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set bit of i_req
// found by scanning upward from i_start and wrapping at N.
// Ports:
//   i_req    N-bit request vector
//   i_start  index where the search begins (must be < N)
//   o_found  at least one request bit is set
//   o_idx    index of the winning request (0 when o_found=0)
// ---------------------------------------------------------------------------
module rr_pick
  import uart_debug_pkg::*;
#(
  parameter int N = DEF_NUM_SRC
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_start,
  output logic         o_found,
  output logic [2:0]   o_idx
);

  // Scan distances from farthest to nearest so the nearest hit is the last
  // assignment and therefore the one that sticks.
  always_comb begin
    o_found = 1'b0;
    o_idx   = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (((int'(i_start) + k) % N == i) && i_req[i]) begin
          o_found = 1'b1;
          o_idx   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Per-message round-robin arbiter that merges NUM_SRC byte streams into one
// UART transmitter. A source keeps the UART from its first byte until its
// byte flagged src_last is accepted; bytes pass through one output register.
//
// Handshake: every stream moves a byte on a clock edge where valid && ready
// are both high. valid must not depend on ready; ready may depend on valid.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   src_valid/data/last/ready   per-source byte streams (data byte i at [8i+7:8i])
//   uart_tx_data/valid/ready    output stream to the UART transmitter
//   grant_active, grant_idx     current owner of the UART
//   msg_count       completed messages (wrapping)
//   drop_count      watchdog-released messages (saturating)
//   timeout_pulse   one-cycle pulse on a watchdog release
//   dbg_state       {state, grant_idx, last_grant} (arb_dbg_t layout)
//
// Configuration macro: UART_ARB_TIMEOUT_EN enables the stall watchdog. Without
// it, drop_count and timeout_pulse are constant 0 and a grant never expires.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_debug_pkg::*;
#(
  parameter int NUM_SRC        = DEF_NUM_SRC,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready,
  output logic                 grant_active,
  output logic [2:0]           grant_idx,
  output logic [15:0]          msg_count,
  output logic [15:0]          drop_count,
  output logic                 timeout_pulse,
  output logic [6:0]           dbg_state
);

  logic        r_state;
  logic [2:0]  r_last_grant;
  logic [2:0]  r_grant_idx;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic [15:0] r_msg_count;

  logic        w_out_free;
  logic        w_sel_valid;
  logic        w_sel_last;
  logic [7:0]  w_sel_data;
  logic        w_src_xfer;
  logic        w_release_last;
  logic        w_timeout;
  logic [2:0]  w_start;
  logic        w_pick_found;
  logic [2:0]  w_pick_idx;
  arb_dbg_t    w_dbg;

  // The output register can take a new byte when empty or draining this cycle.
  assign w_out_free = !r_tx_valid || uart_tx_ready;

  // Mux the granted source and drive its ready; every other ready stays low.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    src_ready   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant_idx == 3'(i)) begin
        w_sel_valid  = src_valid[i];
        w_sel_last   = src_last[i];
        w_sel_data   = src_data[8*i +: 8];
        src_ready[i] = (r_state == ST_GRANT) && w_out_free;
      end
    end
  end

  assign w_src_xfer     = (r_state == ST_GRANT) && w_out_free && w_sel_valid;
  assign w_release_last = w_src_xfer && w_sel_last;
  assign w_start        = next_idx(r_last_grant, NUM_SRC);

  rr_pick #(.N(NUM_SRC)) u_rr_pick (
    .i_req   (src_valid),
    .i_start (w_start),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [15:0]      r_drop_count;
  logic             r_timeout_pulse;

  // The stall cycle that finds the counter at its limit is the one that
  // releases, so a full TIMEOUT_CYCLES stall cycles elapse before release.
  assign w_timeout = (r_state == ST_GRANT) && !w_sel_valid &&
                     (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt     <= '0;
      r_drop_count    <= 16'h0000;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
      if (w_timeout && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
      if ((r_state != ST_GRANT) || w_src_xfer || w_timeout)
        r_stall_cnt <= '0;
      else if (!w_sel_valid)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign drop_count    = r_drop_count;
  assign timeout_pulse = r_timeout_pulse;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign drop_count       = 16'h0000;
  assign timeout_pulse    = 1'b0;
  assign w_unused_timeout = ^(32'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 3'(NUM_SRC - 1);
      r_grant_idx  <= 3'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_msg_count  <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A pending output byte does not block the next grant.
          if (w_pick_found) begin
            r_state     <= ST_GRANT;
            r_grant_idx <= w_pick_idx;
          end
        end
        ST_GRANT: begin
          if (w_release_last || w_timeout) begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_grant_idx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_src_xfer) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_sel_data;
      end else if (uart_tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      if (w_release_last)
        r_msg_count <= r_msg_count + 16'd1;
    end
  end

  assign uart_tx_valid = r_tx_valid;
  assign uart_tx_data  = r_tx_data;
  assign grant_active  = (r_state == ST_GRANT);
  assign grant_idx     = r_grant_idx;
  assign msg_count     = r_msg_count;

  assign w_dbg.state      = r_state;
  assign w_dbg.grant_idx  = r_grant_idx;
  assign w_dbg.last_grant = r_last_grant;
  assign dbg_state        = w_dbg;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of message sources (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 60000: stall limit in cycles for a granted source (1 ms at 60 MHz).
REQ-003 clk  in  1  system clock, 60 MHz; single clock domain.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 src_valid  in  NUM_SRC  per-source byte valid.
REQ-006 src_data  in  NUM_SRC*8  per-source byte; source i occupies bits [8i+7:8i].
REQ-007 src_last  in  NUM_SRC  marks final byte of a source's message.
REQ-008 src_ready  out  NUM_SRC  per-source byte accept.
REQ-009 uart_tx_data  out  8  byte to UART TX.
REQ-010 uart_tx_valid  out  1  byte available to UART TX.
REQ-011 uart_tx_ready  in  1  UART TX accepts byte.
REQ-012 grant_active  out  1  a source currently owns the UART.
REQ-013 grant_idx  out  3  index of owning source (valid when grant_active).
REQ-014 msg_count  out  16  completed messages, wraps at 0xFFFF->0.
REQ-015 drop_count  out  16  timed-out messages, saturates at 0xFFFF.
REQ-016 timeout_pulse  out  1  one-cycle pulse on timeout release.

Function
REQ-017 A byte transfers on a source when src_valid[i] && src_ready[i]; the UART transfers when uart_tx_valid && uart_tx_ready.
REQ-018 States: IDLE, GRANT. IDLE with any src_valid set -> GRANT next cycle; the granted source is the first set src_valid in round-robin order starting at (last_grant+1) mod NUM_SRC.
REQ-019 Arbitration is per message: the grant holds from the first byte to the accepted byte with src_last=1, then the state returns to IDLE and last_grant updates to the released index.
REQ-020 src_ready[i] = (state==GRANT) && (grant_idx==i) && (!uart_tx_valid || uart_tx_ready); all other src_ready bits are 0.
REQ-021 The output register loads on a source transfer; latency from source transfer to uart_tx_valid is 1 cycle; uart_tx_data stays stable while uart_tx_valid=1 and uart_tx_ready=0.
REQ-022 When the output is accepted with no new source transfer in the same cycle, uart_tx_valid clears; back-to-back transfers sustain 1 byte/cycle when uart_tx_ready stays high.
REQ-023 msg_count increments on each accepted src_last byte.
REQ-024 In IDLE, a new grant can be issued while the last byte of the previous message is still pending in the output register.
REQ-025 src_valid deasserting mid-message does not release the grant (except per REQ-031).
REQ-026 With one requester, that requester is re-granted after each message with no idle gap beyond the IDLE cycle.

Reset
REQ-027 While rst_n=0 at a clk edge: state=IDLE, last_grant=NUM_SRC-1 (source 0 wins first), uart_tx_valid=0, uart_tx_data=0x00, src_ready=0, grant_active=0, grant_idx=0, msg_count=0, drop_count=0, timeout_pulse=0, stall counter=0.
REQ-028 Reset mid-message discards the in-flight message and the pending output byte; no partial byte is held.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN enables the stall watchdog.
REQ-030 With the macro defined, the stall counter increments each GRANT cycle with src_valid[grant_idx]=0 and clears on any source transfer or on leaving GRANT.
REQ-031 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1: release to IDLE, pulse timeout_pulse, increment drop_count (saturating), update last_grant, leave msg_count unchanged.
REQ-032 With the macro undefined, no counter logic exists, drop_count and timeout_pulse are tied 0, and the grant holds indefinitely.

Structure
REQ-033 Shared package uart_debug_pkg holds the state encoding, the default NUM_SRC, the default TIMEOUT_CYCLES, and the ASCII constants (CR, LF, '[', ']').
REQ-034 A sub-module rr_pick (combinational round-robin first-set search over NUM_SRC bits from a start index) is instantiated once.

Verification
REQ-035 Sources 0 and 2 each send a 3-byte message simultaneously after reset, uart_tx_ready=1 -> UART sees src0 bytes, then src2 bytes, not interleaved; msg_count=2.
REQ-036 All 4 sources request continuously with 1-byte messages -> grant order 0,1,2,3,0; each src_ready asserts exactly once per rotation.
REQ-037 uart_tx_ready=0 for 10 cycles while a byte is pending -> uart_tx_data is unchanged, src_ready=0 throughout, and no byte is lost or duplicated.
REQ-038 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, source 1 sends 1 byte without last and then drops valid -> release after 16 stall cycles, timeout_pulse=1 for 1 cycle, drop_count=1, and source 2 is granted next.
REQ-039 rst_n=0 for one cycle mid-message -> all outputs take their REQ-027 values on the next cycle, and source 0 is granted first afterwards.
REQ-040 drop_count preset near saturation via 65536 forced timeouts -> holds at 0xFFFF; msg_count 0xFFFF plus one message -> 0x0000.
